mandel_nav: RTL

Parametrised view-navigation controller for the Mandelbrot renderer, in the system clock domain between the debounced buttons and `render_mandel`. Turns pan/zoom/iteration button events into registered `x_start`/`y_start`/`step`/`iter_max` values and issues one `start` pulse per accepted change. Compared with the earlier inline navigation logic, it adds:
- centre-preserving zoom derived from the framebuffer size;
- saturating arithmetic;
- a one-deep pending-command slot instead of silently dropping presses made during a render;
- an optional iteration-limit mode.

---
 rtl/mandel_nav_pkg.sv | 42 ++++
 rtl/mandel_nav_if.sv | 40 ++++
 rtl/mandel_nav_sat_add.sv | 34 +++
 rtl/mandel_nav.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mandel_nav_pkg.sv
// mandel_pkg: shared types for the Mandelbrot view-navigation controller.
//   nav_mode_t  - what a direction button currently does (pan x, pan y, zoom, iterations)
//   nav_state_t - command-processing FSM states
//   nav_cmd_t   - one captured button command: the mode at capture time plus direction
//   next_mode() - mode rotation, with or without the iteration mode
package mandel_pkg;

    typedef enum logic [1:0] {
        HORIZONTAL = 2'd0,
        VERTICAL   = 2'd1,
        ZOOM       = 2'd2,
        ITER       = 2'd3
    } nav_mode_t;

    typedef enum logic [2:0] {
        IDLE,
        CALC,
        COMMIT,
        START,
        HOLD,
        WAIT
    } nav_state_t;

    // dir: DIR_UP = left / up / zoom out / fewer iterations, DIR_DN = the opposite
    localparam logic DIR_UP = 1'b0;
    localparam logic DIR_DN = 1'b1;

    typedef struct packed {
        nav_mode_t mode;
        logic      dir;
    } nav_cmd_t;

    function automatic nav_mode_t next_mode(input nav_mode_t m, input logic iter_en);
        case (m)
            HORIZONTAL: return VERTICAL;
            VERTICAL:   return ZOOM;
            ZOOM:       return iter_en ? ITER : HORIZONTAL;
            default:    return HORIZONTAL;
        endcase
    endfunction

endpackage

// File: rtl/mandel_nav_if.sv
// mandel_nav_if: button-event inputs and view outputs of mandel_nav.
//   sig_mode/sig_up/sig_dn - one-cycle button pulses
//   busy                   - renderer busy
//   x_start/y_start/step   - signed fixed-point view parameters
//   iter_max               - iteration limit
//   start                  - one-cycle render start pulse
//   mode                   - current navigation mode
//   rejected/dropped       - one-cycle status pulses
// master: the navigation controller; slave: the button/renderer side.
interface mandel_nav_if
    import mandel_pkg::*;
#(
    parameter int FP_WIDTH = 25,
    parameter int ITER_W   = 8
);

    logic                       sig_mode;
    logic                       sig_up;
    logic                       sig_dn;
    logic                       busy;
    logic signed [FP_WIDTH-1:0] x_start;
    logic signed [FP_WIDTH-1:0] y_start;
    logic signed [FP_WIDTH-1:0] step;
    logic [ITER_W-1:0]          iter_max;
    logic                       start;
    nav_mode_t                  mode;
    logic                       rejected;
    logic                       dropped;

    modport master (
        input  sig_mode, sig_up, sig_dn, busy,
        output x_start, y_start, step, iter_max, start, mode, rejected, dropped
    );

    modport slave (
        output sig_mode, sig_up, sig_dn, busy,
        input  x_start, y_start, step, iter_max, start, mode, rejected, dropped
    );

endinterface

// File: rtl/mandel_nav_sat_add.sv
// sat_add: signed add/subtract of two WIDTH-bit operands, evaluated with two
// guard bits and saturated back into the signed WIDTH-bit range.
//   a, b - signed operands
//   sub  - 1: y = a - b, 0: y = a + b
//   y    - saturated result
module sat_add #(
    parameter int WIDTH = 25
) (
    input  logic signed [WIDTH-1:0] a,
    input  logic signed [WIDTH-1:0] b,
    input  logic                    sub,
    output logic signed [WIDTH-1:0] y
);

    localparam int EW = WIDTH + 2;
    localparam logic signed [EW-1:0] MAX_EXT = {3'b000, {(WIDTH-1){1'b1}}};
    localparam logic signed [EW-1:0] MIN_EXT = {3'b111, {(WIDTH-1){1'b0}}};

    logic signed [EW-1:0] sum;

    // Two guard bits hold any sum or difference of two WIDTH-bit values exactly,
    // so the range test below is always meaningful.
    always_comb begin
        sum = sub ? (EW'(a) - EW'(b)) : (EW'(a) + EW'(b));
        if (sum > MAX_EXT) begin
            y = MAX_EXT[WIDTH-1:0];
        end else if (sum < MIN_EXT) begin
            y = MIN_EXT[WIDTH-1:0];
        end else begin
            y = sum[WIDTH-1:0];
        end
    end

endmodule

// File: rtl/mandel_nav.sv
// mandel_nav: view-navigation controller between the debounced buttons and the
// renderer. Button pulses become commands that pan, zoom (centre-preserving) or
// change the iteration limit; each accepted change updates the registered view
// and issues one start pulse. A command that arrives while a change or render
// is in progress waits in a one-deep pending slot.
//   clk, rst - system clock, synchronous active-high reset
//   bus      - mandel_nav_if.master (buttons, busy, view outputs, status pulses)
// Build option: define MANDEL_NAV_ITER_EN to add the ITER mode and a writable
// iteration limit; otherwise iter_max is the constant ITER_MAX.
module mandel_nav
    import mandel_pkg::*;
#(
    parameter int  FP_WIDTH  = 25,
    parameter int  FP_INT    = 4,
    parameter int  FB_WIDTH  = 320,
    parameter int  FB_HEIGHT = 180,
    parameter int  PAN_SHIFT = 4,
    parameter real X_START   = -3.5,
    parameter real Y_START   = -1.5,
    parameter real STEP_INIT = 1.0 / 64.0,
    parameter int  STEP_MIN  = 1,
    parameter real STEP_MAX  = STEP_INIT,
    parameter int  ITER_MAX  = 255,
    parameter int  ITER_MIN  = 127
) (
    input logic          clk,
    input logic          rst,
    mandel_nav_if.master bus
);

    localparam int  EW     = FP_WIDTH + 2;
    localparam int  ITER_W = $clog2(ITER_MAX + 1);
    localparam real SCALE  = 2.0 ** (FP_WIDTH - FP_INT);

    localparam logic signed [FP_WIDTH-1:0] X_START_FP  = FP_WIDTH'($rtoi(X_START * SCALE));
    localparam logic signed [FP_WIDTH-1:0] Y_START_FP  = FP_WIDTH'($rtoi(Y_START * SCALE));
    localparam logic signed [FP_WIDTH-1:0] STEP_INIT_FP = FP_WIDTH'($rtoi(STEP_INIT * SCALE));
    localparam logic signed [FP_WIDTH-1:0] STEP_MIN_FP = FP_WIDTH'(STEP_MIN);
    localparam logic signed [EW-1:0]       STEP_MAX_EXT = EW'($rtoi(STEP_MAX * SCALE));
    localparam logic signed [EW-1:0]       MAX_EXT     = {3'b000, {(FP_WIDTH-1){1'b1}}};
    localparam logic signed [EW-1:0]       MIN_EXT     = {3'b111, {(FP_WIDTH-1){1'b0}}};

    // Zoom offsets: a quarter screen forwards on zoom in, half a screen back on
    // zoom out, which keeps the view centre fixed.
    localparam logic signed [EW-1:0] K_XQ = EW'(FB_WIDTH / 4);
    localparam logic signed [EW-1:0] K_XH = EW'(FB_WIDTH / 2);
    localparam logic signed [EW-1:0] K_YQ = EW'(FB_HEIGHT / 4);
    localparam logic signed [EW-1:0] K_YH = EW'(FB_HEIGHT / 2);

    nav_state_t                 state;
    nav_mode_t                  mode_q;
    nav_cmd_t                   cmd_q;
    nav_cmd_t                   pend_q;
    nav_cmd_t                   new_cmd;
    logic                       pend_valid;
    logic                       cmd_in;
    logic                       start_q;
    logic                       rejected_q;
    logic                       dropped_q;
    logic signed [FP_WIDTH-1:0] x_q, y_q, step_q;
    logic signed [FP_WIDTH-1:0] x_p, y_p, step_p;
    logic                       legal_p;
    logic signed [FP_WIDTH-1:0] x_cand, y_cand, step_cand, dx, dy;
    logic signed [EW-1:0]       step_ext, step_dbl, dx_ext, dy_ext;
    logic                       view_legal;

    function automatic logic signed [FP_WIDTH-1:0] clamp(input logic signed [EW-1:0] v);
        if (v > MAX_EXT) begin
            return MAX_EXT[FP_WIDTH-1:0];
        end else if (v < MIN_EXT) begin
            return MIN_EXT[FP_WIDTH-1:0];
        end
        return v[FP_WIDTH-1:0];
    endfunction

    // sig_up wins over sig_dn; the command carries the mode in force before any
    // same-cycle sig_mode takes effect.
    assign cmd_in  = bus.sig_up | bus.sig_dn;
    assign new_cmd = '{mode: mode_q, dir: (bus.sig_up ? DIR_UP : DIR_DN)};

`ifdef MANDEL_NAV_ITER_EN
    localparam logic ITER_EN = 1'b1;

    logic [ITER_W-1:0] iter_q, iter_p, iter_cand;
    logic [ITER_W:0]   iter_dbl;
    logic              iter_legal;

    // More iterations: 2n+1 (next all-ones value). Fewer: n>>1.
    always_comb begin
        iter_dbl = {iter_q, 1'b1};
        if (cmd_q.dir == DIR_DN) begin
            iter_cand  = iter_dbl[ITER_W-1:0];
            iter_legal = (iter_dbl <= (ITER_W+1)'(ITER_MAX));
        end else begin
            iter_cand  = iter_q >> 1;
            iter_legal = (iter_cand >= ITER_W'(ITER_MIN));
        end
    end

    assign bus.iter_max = iter_q;
`else
    localparam logic ITER_EN = 1'b0;

    assign bus.iter_max = ITER_W'(ITER_MAX);
`endif

    assign step_ext = EW'(step_q);
    assign step_dbl = step_ext <<< 1;

    // Offset selection for the captured command. Every direction maps onto
    // "add for DIR_DN, subtract for DIR_UP", so the adders share one sub control.
    always_comb begin
        dx_ext     = '0;
        dy_ext     = '0;
        step_cand  = step_q;
        view_legal = 1'b1;
        case (cmd_q.mode)
            HORIZONTAL: dx_ext = step_ext <<< PAN_SHIFT;
            VERTICAL:   dy_ext = step_ext <<< PAN_SHIFT;
            ZOOM: begin
                if (cmd_q.dir == DIR_DN) begin
                    dx_ext     = step_ext * K_XQ;
                    dy_ext     = step_ext * K_YQ;
                    step_cand  = step_q >>> 1;
                    view_legal = ((step_q >>> 1) >= STEP_MIN_FP);
                end else begin
                    dx_ext     = step_ext * K_XH;
                    dy_ext     = step_ext * K_YH;
                    step_cand  = step_dbl[FP_WIDTH-1:0];
                    view_legal = (step_dbl <= STEP_MAX_EXT);
                end
            end
            default: begin
`ifdef MANDEL_NAV_ITER_EN
                view_legal = iter_legal;
`endif
            end
        endcase
        dx = clamp(dx_ext);
        dy = clamp(dy_ext);
    end

    sat_add #(.WIDTH(FP_WIDTH)) u_sat_x (
        .a   (x_q),
        .b   (dx),
        .sub (cmd_q.dir == DIR_UP),
        .y   (x_cand)
    );

    sat_add #(.WIDTH(FP_WIDTH)) u_sat_y (
        .a   (y_q),
        .b   (dy),
        .sub (cmd_q.dir == DIR_UP),
        .y   (y_cand)
    );

    // Command FSM. Reset parks it in START with start low so that the first
    // clock after reset raises start for one cycle (initial render). The
    // pending-slot write comes after the case so it overrides the slot release
    // in IDLE when a new press lands in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= START;
            mode_q     <= HORIZONTAL;
            cmd_q      <= '{mode: HORIZONTAL, dir: DIR_UP};
            pend_q     <= '{mode: HORIZONTAL, dir: DIR_UP};
            pend_valid <= 1'b0;
            start_q    <= 1'b0;
            rejected_q <= 1'b0;
            dropped_q  <= 1'b0;
            x_q        <= X_START_FP;
            y_q        <= Y_START_FP;
            step_q     <= STEP_INIT_FP;
            x_p        <= X_START_FP;
            y_p        <= Y_START_FP;
            step_p     <= STEP_INIT_FP;
            legal_p    <= 1'b0;
`ifdef MANDEL_NAV_ITER_EN
            iter_q     <= ITER_W'(ITER_MAX);
            iter_p     <= ITER_W'(ITER_MAX);
`endif
        end else begin
            rejected_q <= 1'b0;
            dropped_q  <= 1'b0;
            if (bus.sig_mode) begin
                mode_q <= next_mode(mode_q, ITER_EN);
            end

            case (state)
                IDLE: begin
                    if (pend_valid) begin
                        cmd_q      <= pend_q;
                        pend_valid <= 1'b0;
                        state      <= CALC;
                    end else if (cmd_in) begin
                        cmd_q <= new_cmd;
                        state <= CALC;
                    end
                end
                CALC: begin
                    x_p     <= x_cand;
                    y_p     <= y_cand;
                    step_p  <= step_cand;
                    legal_p <= view_legal;
`ifdef MANDEL_NAV_ITER_EN
                    iter_p  <= (cmd_q.mode == ITER) ? iter_cand : iter_q;
`endif
                    state   <= COMMIT;
                end
                COMMIT: begin
                    if (legal_p) begin
                        x_q     <= x_p;
                        y_q     <= y_p;
                        step_q  <= step_p;
`ifdef MANDEL_NAV_ITER_EN
                        iter_q  <= iter_p;
`endif
                        start_q <= 1'b1;
                        state   <= START;
                    end else begin
                        rejected_q <= 1'b1;
                        state      <= IDLE;
                    end
                end
                START: begin
                    if (start_q) begin
                        start_q <= 1'b0;
                        state   <= HOLD;
                    end else begin
                        start_q <= 1'b1;
                    end
                end
                HOLD: state <= WAIT;
                default: begin
                    if (!bus.busy) begin
                        state <= IDLE;
                    end
                end
            endcase

            if (cmd_in && !(state == IDLE && !pend_valid)) begin
                if (!pend_valid || state == IDLE) begin
                    pend_q     <= new_cmd;
                    pend_valid <= 1'b1;
                end else begin
                    dropped_q <= 1'b1;
                end
            end
        end
    end

    assign bus.x_start  = x_q;
    assign bus.y_start  = y_q;
    assign bus.step     = step_q;
    assign bus.start    = start_q;
    assign bus.mode     = mode_q;
    assign bus.rejected = rejected_q;
    assign bus.dropped  = dropped_q;

endmodule
